mul_fork: RTL and testbench
===========================

# mul_fork

Consumer-side fork for the multiplier result stream. It accepts one valid/ready stream of WD-bit words in the `{|product, product}` format, checks the flag bit, and broadcasts each word unchanged to two independent valid/ready consumers. Each word retires only after both consumers have taken it. It sits directly downstream of the multiplier output pipe and feeds the scoreboard-side and datapath-side sinks.

## Interface
- WD, 9, word width; bit WD-1 is the flag, bits WD-2:0 are the product.
- CNT_WD, 16, width of the error counter.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input word valid.
- s_data  in  WD  input word.
- s_ready  out  1  input ready.
- m0_valid  out  1  branch 0 valid.
- m0_data  out  WD  branch 0 word.
- m0_ready  in  1  branch 0 ready.
- m1_valid  out  1  branch 1 valid.
- m1_data  out  WD  branch 1 word.
- m1_ready  in  1  branch 1 ready.
- err_cnt  out  CNT_WD  count of accepted words with a bad flag; saturating.
- err_flag  out  1  sticky; set on the first bad word, cleared only by rst.

## Operation
- One-entry holding register with these fields: `full`, `data[WD]`, `done0`, `done1`.
- Branch valids:
  - m0_valid = full & !done0
  - m1_valid = full & !done1
  - m0_data = m1_data = data
- Branch handshakes:
  - hs0 = m0_valid & m0_ready
  - hs1 = m1_valid & m1_ready
- Retire condition: retire = full & (done0 | hs0) & (done1 | hs1).
- Input ready: s_ready = !rst & (!full | retire). This gives full-rate pass-through when both branches are ready.
- Input accept (s_valid & s_ready):
  - load data, set full, clear done0 and done1.
- Retire without a new accept:
  - clear full, done0 and done1.
- Partial handshake (no retire):
  - a branch that hands over sets its done bit; the other branch keeps valid and data stable.
- Flag check on input accept:
  - the word is bad when s_data[WD-1] != |s_data[WD-2:0].
  - a bad word increments err_cnt (saturating at all-ones) and sets err_flag.
- Data is never modified or dropped because of a bad flag.
- State machine, per entry: EMPTY, WAIT_BOTH, WAIT_0, WAIT_1.
  - EMPTY -> WAIT_BOTH on accept.
  - WAIT_BOTH -> WAIT_1 on hs0 only; -> WAIT_0 on hs1 only.
  - WAIT_x -> EMPTY on its handshake, or -> WAIT_BOTH if an accept happens in the same cycle.
  - WAIT_BOTH -> EMPTY or WAIT_BOTH when both handshakes occur in the same cycle.

## Timing
- Reset values: full=0, done0=0, done1=0, data=0, err_cnt=0, err_flag=0.
  - Outputs during and after reset: m0_valid=0, m1_valid=0, m0_data=0, m1_data=0.
  - s_ready=0 while rst=1, and 1 in the first cycle after rst falls.
- Latency: a word accepted in cycle n is valid on both branches in cycle n+1.
- Throughput: one word per cycle when both branch readies are held high.
- Valid and data on a branch are held stable until that branch handshakes. A branch valid never drops before its handshake.
- Branch valids do not depend on branch readies.
- Mid-operation reset: the held word is discarded with no output handshake, the counter clears, and s_ready is low during the reset cycle.
- Saturation: err_cnt stays at 2^CNT_WD-1. err_flag stays at 1.

## Structure
- Package `mul_pkg` holds:
  - the WD default;
  - the flag-encode function `mul_flag(product)`, which is |product;
  - the word-valid check function.
- Sub-module `hand_fork #(.CHL(2))`, the dual of hand_merge, owns the done bits, the branch valids and the retire logic.
- The top level holds the data register, the flag check and the error counter.

## Test plan
- Reset: hold rst=1 for 3 cycles with s_valid=1 -> s_ready=0, both branch valids 0, err_cnt=0; after release s_ready=1.
- Single good word 9'h10C with both readies high -> accepted in cycle 0; m0_valid and m1_valid high with data 9'h10C in cycle 1; both retire in cycle 1; err_cnt=0.
- Skewed branches: stream 9'h101, 9'h102 with m0_ready=1 and m1_ready=0 for 4 cycles, then 1:
  - m0 takes 9'h101 once, and m0_valid then stays 0;
  - m1 holds 9'h101 stable;
  - s_ready stays 0 until the m1 handshake, and 9'h102 is accepted in that same cycle.
- Bad words: inputs 9'h005, 9'h100, 9'h000, 9'h1FF -> err_cnt=2, err_flag=1, and all four words appear unchanged and in order on both branches.
- Back-to-back: 8 words 9'h101..9'h108 with both readies high -> one word per cycle on each branch, order preserved, no bubbles.
- Saturation and reset mid-flight with CNT_WD=2:
  - 5 bad words -> err_cnt=3.
  - assert rst while a word is held in WAIT_1 -> err_cnt=0, err_flag=0, branch valids 0 in the next cycle, and the held word is never delivered.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier result stream: default word width
// and the {|product, product} flag encode/check helpers.
package mul_pkg;

   localparam int MUL_WD    = 9;
   localparam int MUL_MAX_W = 64;

   function automatic logic mul_flag(input logic [MUL_MAX_W-1:0] product);
      return |product;
   endfunction

   // Narrower products are passed zero-extended, which leaves the OR-reduce unchanged.
   function automatic logic mul_word_ok(input logic flag, input logic [MUL_MAX_W-1:0] product);
      return flag == mul_flag(product);
   endfunction

endpackage

// File: rtl/hand_fork.sv
// Valid/ready fork control: one upstream slot broadcast to CHL consumers,
// retiring only once every consumer has taken the held word.
module hand_fork #(
   parameter int CHL = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_valid,
   output logic           s_ready,
   output logic           accept,
   output logic [CHL-1:0] m_valid,
   input  logic [CHL-1:0] m_ready
);

   logic           full_p1;
   logic [CHL-1:0] done_p1;
   logic [CHL-1:0] hs;
   logic           retire;

   assign m_valid = {CHL{full_p1}} & ~done_p1;
   assign hs      = m_valid & m_ready;
   assign retire  = full_p1 & (&(done_p1 | hs));
   assign s_ready = !rst & (!full_p1 | retire);
   assign accept  = s_valid & s_ready;

   // Slot state: EMPTY (!full), WAIT_BOTH (full, no done), WAIT_x (one branch done)
   always_ff @(posedge clk) begin
      if (rst) begin
         full_p1 <= 1'b0;
         done_p1 <= '0;
      end else if (accept) begin
         full_p1 <= 1'b1;
         done_p1 <= '0;
      end else if (retire) begin
         full_p1 <= 1'b0;
         done_p1 <= '0;
      end else begin
         done_p1 <= done_p1 | hs;
      end
   end

endmodule

// File: rtl/mul_fork.sv
// Multiplier result fork: broadcasts each word to two consumers unchanged
// and counts accepted words whose flag bit disagrees with the product.
module mul_fork
   import mul_pkg::*;
#(
   parameter int WD     = MUL_WD,
   parameter int CNT_WD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [WD-1:0]     s_data,
   output logic              s_ready,
   output logic              m0_valid,
   output logic [WD-1:0]     m0_data,
   input  logic              m0_ready,
   output logic              m1_valid,
   output logic [WD-1:0]     m1_data,
   input  logic              m1_ready,
   output logic [CNT_WD-1:0] err_cnt,
   output logic              err_flag
);

   function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] c);
      return (c == {CNT_WD{1'b1}}) ? c : c + 1'b1;
   endfunction

   logic              accept;
   logic [1:0]        m_valid;
   logic              bad_p0;
   logic [WD-1:0]     data_p1;
   logic [CNT_WD-1:0] err_cnt_p1;
   logic              err_flag_p1;

   hand_fork #(.CHL(2)) u_fork (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .accept  (accept),
      .m_valid (m_valid),
      .m_ready ({m1_ready, m0_ready})
   );

   assign bad_p0 = !mul_word_ok(s_data[WD-1], MUL_MAX_W'(s_data[WD-2:0]));

   // Accept stage: capture the word and account for a bad flag
   always_ff @(posedge clk) begin
      if (rst) begin
         data_p1     <= '0;
         err_cnt_p1  <= '0;
         err_flag_p1 <= 1'b0;
      end else if (accept) begin
         data_p1 <= s_data;
         if (bad_p0) begin
            err_cnt_p1  <= sat_inc(err_cnt_p1);
            err_flag_p1 <= 1'b1;
         end
      end
   end

   assign m0_valid = m_valid[0];
   assign m1_valid = m_valid[1];
   assign m0_data  = data_p1;
   assign m1_data  = data_p1;
   assign err_cnt  = err_cnt_p1;
   assign err_flag = err_flag_p1;

endmodule

// File: tb/tb_mul_fork.sv
// Scoreboard bench for mul_fork: a default instance and a CNT_WD=2 instance
// share all stimulus; words and bad-word counts are predicted by the bench.
module tb_mul_fork;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic [8:0]  s_data = '0;
   logic        m0_ready = 1'b0;
   logic        m1_ready = 1'b0;
   logic        s_ready, m0_valid, m1_valid, err_flag;
   logic [8:0]  m0_data, m1_data;
   logic [15:0] err_cnt;
   logic        s_ready2, m0_valid2, m1_valid2, err_flag2;
   logic [8:0]  m0_data2, m1_data2;
   logic [1:0]  err_cnt2;

   int total = 0;
   int bad = 0;
   int n_bad = 0;
   bit mon_en = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];

   always #5 clk = ~clk;

   mul_fork dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m0_valid(m0_valid), .m0_data(m0_data), .m0_ready(m0_ready),
      .m1_valid(m1_valid), .m1_data(m1_data), .m1_ready(m1_ready),
      .err_cnt(err_cnt), .err_flag(err_flag)
   );

   mul_fork #(.WD(9), .CNT_WD(2)) dut2 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2),
      .m0_valid(m0_valid2), .m0_data(m0_data2), .m0_ready(m0_ready),
      .m1_valid(m1_valid2), .m1_data(m1_data2), .m1_ready(m1_ready),
      .err_cnt(err_cnt2), .err_flag(err_flag2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sat(input int n, input int mx);
      return (n > mx) ? mx : n;
   endfunction

   // One clock: sample handshakes mid-cycle, update the reference at the edge.
   task automatic step(output bit acc, output bit h0, output bit h1);
      bit r;
      logic [8:0] w;
      @(negedge clk);
      r   = rst;
      acc = s_valid && s_ready && !rst;
      h0  = m0_valid && m0_ready;
      h1  = m1_valid && m1_ready;
      w   = s_data;
      @(posedge clk);
      if (r) begin
         q0.delete();
         q1.delete();
         n_bad = 0;
      end else if (acc) begin
         q0.push_back(w);
         q1.push_back(w);
         if (w[8] != (w[7:0] != 8'd0)) n_bad++;
      end
      #1;
   endtask

   task automatic send(input logic [8:0] w, output int waited, output bit h1_at_acc);
      bit acc, h0, h1;
      s_valid = 1'b1;
      s_data  = w;
      waited  = 0;
      h1_at_acc = 0;
      for (int i = 0; i < 200; i++) begin
         step(acc, h0, h1);
         if (acc) begin
            h1_at_acc = h1;
            return;
         end
         waited++;
      end
      total++;
      bad++;
      $display("FAIL send_timeout: word %0h not accepted, required acceptance within 200 cycles", w);
   endtask

   task automatic idle(input int n);
      bit a, b, c;
      for (int i = 0; i < n; i++) step(a, b, c);
   endtask

   // Monitor: pops the scoreboard on each branch handshake and checks stability/counters
   bit         hold0 = 0, hold1 = 0;
   logic [8:0] hold0_d, hold1_d;
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            chk("s_ready_in_rst", s_ready, 0);
         end else begin
            if (hold0) begin
               chk("m0_hold_valid", m0_valid, 1);
               chk("m0_hold_data", m0_data, hold0_d);
            end
            if (hold1) begin
               chk("m1_hold_valid", m1_valid, 1);
               chk("m1_hold_data", m1_data, hold1_d);
            end
            if (m0_valid && m0_ready) begin
               if (q0.size() == 0) begin
                  total++; bad++;
                  $display("FAIL m0_unexpected: got word %0h required no delivery", m0_data);
               end else chk("m0_data", m0_data, q0.pop_front());
            end
            if (m1_valid && m1_ready) begin
               if (q1.size() == 0) begin
                  total++; bad++;
                  $display("FAIL m1_unexpected: got word %0h required no delivery", m1_data);
               end else chk("m1_data", m1_data, q1.pop_front());
            end
         end
         chk("err_cnt", err_cnt, sat(n_bad, 65535));
         chk("err_cnt_w2", err_cnt2, sat(n_bad, 3));
         chk("err_flag", err_flag, n_bad != 0);
         chk("err_flag_w2", err_flag2, n_bad != 0);
      end
      hold0   = !rst && m0_valid && !m0_ready;
      hold1   = !rst && m1_valid && !m1_ready;
      hold0_d = m0_data;
      hold1_d = m1_data;
   end

   initial begin
      bit acc, h0, h1, h1a;
      int waited;

      // Reset held with s_valid high
      rst = 1'b1; s_valid = 1'b1; s_data = 9'h10C; m0_ready = 1'b1; m1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(acc, h0, h1);
         chk("rst_s_ready", s_ready, 0);
         chk("rst_m0_valid", m0_valid, 0);
         chk("rst_m1_valid", m1_valid, 0);
         chk("rst_m0_data", m0_data, 0);
         chk("rst_err_cnt", err_cnt, 0);
      end
      rst = 1'b0; s_valid = 1'b0;
      #1;
      chk("post_rst_s_ready", s_ready, 1);
      mon_en = 1;

      // Single good word
      send(9'h10C, waited, h1a);
      s_valid = 1'b0;
      chk("single_wait", waited, 0);
      chk("single_m0_valid", m0_valid, 1);
      chk("single_m1_valid", m1_valid, 1);
      chk("single_m0_data", m0_data, 9'h10C);
      chk("single_m1_data", m1_data, 9'h10C);
      step(acc, h0, h1);
      chk("single_retire0", m0_valid, 0);
      chk("single_retire1", m1_valid, 0);

      // Skewed branches
      m0_ready = 1'b1; m1_ready = 1'b0;
      send(9'h101, waited, h1a);
      s_data = 9'h102;
      for (int i = 0; i < 3; i++) begin
         step(acc, h0, h1);
         chk("skew_m0_valid", m0_valid, 0);
         chk("skew_m1_valid", m1_valid, 1);
         chk("skew_m1_data", m1_data, 9'h101);
         chk("skew_s_ready", s_ready, 0);
      end
      m1_ready = 1'b1;
      send(9'h102, waited, h1a);
      s_valid = 1'b0;
      chk("skew_accept_wait", waited, 0);
      chk("skew_accept_with_m1_hs", h1a, 1);
      idle(3);

      // Bad-flag words
      rst = 1'b1; idle(1); rst = 1'b0;
      send(9'h005, waited, h1a);
      send(9'h100, waited, h1a);
      send(9'h000, waited, h1a);
      send(9'h1FF, waited, h1a);
      s_valid = 1'b0;
      idle(3);
      chk("bad_err_cnt", err_cnt, 2);
      chk("bad_err_flag", err_flag, 1);

      // Back-to-back
      for (int i = 1; i <= 8; i++) begin
         send(9'h100 + 9'(i), waited, h1a);
         chk("b2b_no_bubble", waited, 0);
         if (i > 1) chk("b2b_m1_hs_each_cycle", h1a, 1);
      end
      s_valid = 1'b0;
      idle(3);

      // Saturation and reset while a word waits on branch 1
      rst = 1'b1; idle(1); rst = 1'b0;
      for (int i = 0; i < 5; i++) send(9'h001 + 9'(i), waited, h1a);
      s_valid = 1'b0;
      idle(2);
      chk("sat_err_cnt_w2", err_cnt2, 3);
      chk("sat_err_cnt", err_cnt, 5);
      m1_ready = 1'b0;
      send(9'h0AA, waited, h1a);
      s_valid = 1'b0;
      step(acc, h0, h1);
      chk("wait1_m0_valid", m0_valid, 0);
      chk("wait1_m1_valid", m1_valid, 1);
      rst = 1'b1;
      step(acc, h0, h1);
      chk("midrst_s_ready", s_ready, 0);
      chk("midrst_m0_valid", m0_valid, 0);
      chk("midrst_m1_valid", m1_valid, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      chk("midrst_err_cnt_w2", err_cnt2, 0);
      chk("midrst_err_flag", err_flag, 0);
      rst = 1'b0; m1_ready = 1'b1;
      idle(3);
      chk("midrst_no_delivery", m1_valid, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         s_valid  = ($urandom_range(0, 3) != 0);
         s_data   = 9'($urandom);
         m0_ready = ($urandom_range(0, 2) != 0);
         m1_ready = ($urandom_range(0, 2) != 0);
         step(acc, h0, h1);
      end
      s_valid = 1'b0; m0_ready = 1'b1; m1_ready = 1'b1;
      idle(4);
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
